quant_sequencer: RTL and testbench

QUANT_SEQUENCER -- requirements
Module: quant_sequencer

---
 rtl/quant_sequencer_if.sv | 48 ++++
 rtl/quant_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_quant_sequencer.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/quant_sequencer_if.sv
// quant_sequencer_if: control, upstream feature stream, quantizer drive and downstream
// handshake of quant_sequencer. err_nan exists only when QSEQ_NAN_GUARD_EN is defined.
// slave = the sequencer itself, master = the logic around it that feeds and drains it.
interface quant_sequencer_if #(
  parameter int IDX_W = 10
);
  // frame control
  logic             start;
  logic             abort;
  logic             busy;
  logic             done;
  // upstream float32 feature stream
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_data;
  // shared combinational quantizer
  logic [31:0]      q_value;
  logic             q_en;
  logic             q_nrst;
  logic [3:0]       q_level;
  // downstream toward the item-memory LUT
  logic             out_valid;
  logic             out_ready;
  logic [3:0]       out_level;
  logic [IDX_W-1:0] out_index;
  logic             out_last;
`ifdef QSEQ_NAN_GUARD_EN
  logic             err_nan;
`endif

  modport slave (
    input  start, abort, in_valid, in_data, q_level, out_ready,
    output busy, done, in_ready, q_value, q_en, q_nrst,
           out_valid, out_level, out_index, out_last
`ifdef QSEQ_NAN_GUARD_EN
    , output err_nan
`endif
  );

  modport master (
    output start, abort, in_valid, in_data, q_level, out_ready,
    input  busy, done, in_ready, q_value, q_en, q_nrst,
           out_valid, out_level, out_index, out_last
`ifdef QSEQ_NAN_GUARD_EN
    , input err_nan
`endif
  );
endinterface

// File: rtl/quant_sequencer.sv
// quant_sequencer: walks one sample frame, fetching each float32 feature, quantizing it
// through the shared quantizer and emitting (level, index, last) downstream.
// Latency 3 cycles per feature (FETCH, QUANT, EMIT); one feature in flight, EMIT holds until out_ready.
// Optional macro QSEQ_NAN_GUARD_EN: NaN/Inf inputs emit level 4 and raise sticky err_nan.
module quant_sequencer #(
  parameter int NUM_FEATURES = 617,
  parameter int IDX_W        = 10
) (
  input logic              clk,
  input logic              rst,
  quant_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_QUANT = 3'd2,
    ST_EMIT  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_FEATURES - 1);
  localparam logic [3:0]       MAX_LEVEL = 4'd9;
`ifdef QSEQ_NAN_GUARD_EN
  localparam logic [3:0]       NAN_LEVEL = 4'd4;
`endif

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [31:0]      hold_q, hold_d;
  logic [3:0]       level_q, level_d;
  logic             is_last;
  logic [3:0]       q_level_clamped;
`ifdef QSEQ_NAN_GUARD_EN
  logic             nan_q, nan_d;
  logic             err_nan_q, err_nan_d;
`endif

  assign is_last         = (idx_q == LAST_IDX);
  // The quantizer only defines levels 0..9; anything above is treated as the most negative bucket.
  assign q_level_clamped = (bus.q_level > MAX_LEVEL) ? MAX_LEVEL : bus.q_level;

  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.q_nrst    = !rst;
  assign bus.out_level = level_q;
  assign bus.out_index = idx_q;
  // Gated by rst so that every output except q_nrst reads 0 during reset even when NUM_FEATURES == 1.
  assign bus.out_last  = is_last && !rst;
`ifdef QSEQ_NAN_GUARD_EN
  assign bus.err_nan   = err_nan_q;
`endif

  // Next-state, datapath next values and Moore outputs; abort overrides everything at the end.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    hold_d        = hold_q;
    level_d       = level_q;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.done      = 1'b0;
    bus.q_en      = 1'b0;
    bus.q_value   = '0;
`ifdef QSEQ_NAN_GUARD_EN
    nan_d         = nan_q;
    err_nan_d     = err_nan_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_FETCH;
          idx_d   = '0;
`ifdef QSEQ_NAN_GUARD_EN
          err_nan_d = 1'b0;
`endif
        end
      end

      ST_FETCH: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          hold_d  = bus.in_data;
          state_d = ST_QUANT;
`ifdef QSEQ_NAN_GUARD_EN
          // All-ones exponent means NaN or Inf; the quantizer result is meaningless for those.
          nan_d = &bus.in_data[30:23];
          if (&bus.in_data[30:23]) begin
            err_nan_d = 1'b1;
          end
`endif
        end
      end

      ST_QUANT: begin
        bus.q_en    = 1'b1;
        bus.q_value = hold_q;
`ifdef QSEQ_NAN_GUARD_EN
        level_d = nan_q ? NAN_LEVEL : q_level_clamped;
`else
        level_d = q_level_clamped;
`endif
        state_d = ST_EMIT;
      end

      ST_EMIT: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) begin
          if (is_last) begin
            state_d = ST_DONE;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = ST_FETCH;
          end
        end
      end

      ST_DONE: begin
        bus.done = 1'b1;
        idx_d    = '0;
        state_d  = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end
    endcase

    // Handshakes are suppressed during abort so nothing is consumed or delivered in that cycle.
    if (bus.abort) begin
      state_d       = ST_IDLE;
      idx_d         = '0;
      hold_d        = hold_q;
      level_d       = level_q;
      bus.in_ready  = 1'b0;
      bus.out_valid = 1'b0;
      bus.done      = 1'b0;
`ifdef QSEQ_NAN_GUARD_EN
      nan_d         = nan_q;
      err_nan_d     = err_nan_q;
`endif
    end
  end

  // State, index, holding and level registers; all return to zero on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      hold_q  <= '0;
      level_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      hold_q  <= hold_d;
      level_q <= level_d;
    end
  end

`ifdef QSEQ_NAN_GUARD_EN
  // NaN flag for the feature in flight and the sticky error seen by software.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nan_q     <= 1'b0;
      err_nan_q <= 1'b0;
    end else begin
      nan_q     <= nan_d;
      err_nan_q <= err_nan_d;
    end
  end
`endif

  // Downstream sees stable data until it accepts, unless the frame is aborted.
  a_out_stable: assert property (@(posedge clk) disable iff (rst)
    (bus.out_valid && !bus.out_ready) |=>
      (bus.abort || (bus.out_valid && $stable(bus.out_level) && $stable(bus.out_index))));

  // Only one feature may be in flight: never accept input while output is pending.
  a_one_in_flight: assert property (@(posedge clk) disable iff (rst)
    !(bus.in_ready && bus.out_valid));

  // done is a single-cycle pulse.
  a_done_pulse: assert property (@(posedge clk) disable iff (rst)
    bus.done |=> !bus.done);

endmodule

// File: tb/tb_quant_sequencer.sv
// Bench for quant_sequencer with a 3-feature frame and a table-driven quantizer model.
// Expected (level, index, last) tuples are queued as each feature is accepted upstream
// and compared when the sequencer hands the result downstream.
module tb_quant_sequencer;
  localparam int NF    = 3;
  localparam int IDX_W = 10;

  typedef struct packed {
    logic [3:0]       lvl;
    logic [IDX_W-1:0] idx;
    logic             last;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  int         checks = 0;
  int         passed = 0;
  logic       force_en = 1'b0;
  logic [3:0] force_val = 4'd0;
  exp_t       exp_q[$];

  quant_sequencer_if #(.IDX_W(IDX_W)) bus ();

  quant_sequencer #(.NUM_FEATURES(NF), .IDX_W(IDX_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Quantizer model: +1.0 -> 0, -1.0 -> 9, everything else (incl. 0.0) -> 5, or a forced value.
  always_comb begin
    bus.q_level = 4'd5;
    if (force_en) begin
      bus.q_level = force_val;
    end else begin
      case (bus.q_value)
        32'h3F800000: bus.q_level = 4'd0;
        32'hBF800000: bus.q_level = 4'd9;
        default:      bus.q_level = 4'd5;
      endcase
    end
  end

  // Runs one frame from start; optional stall of the first emit, abort in QUANT at a given index,
  // and start pulses while busy.
  task automatic run_frame(input logic [31:0] d [NF], input logic [3:0] lv [NF],
                           input int stall, input int abort_at, input bit poke_start);
    int fed = 0;
    int got = 0;
    int stalled = 0;
    int cyc = 0;
    bit finished = 0;
    bit aborted = 0;
    logic [3:0] s_lvl = '0;
    logic [IDX_W-1:0] s_idx = '0;
    exp_t e;
    exp_q.delete();
    @(negedge clk);
    bus.start = 1'b1; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    while (!finished && !aborted && cyc < 200) begin
      @(negedge clk);
      cyc++;
      bus.start    = 1'b0;
      bus.abort    = 1'b0;
      bus.in_valid = (fed < NF);
      bus.in_data  = (fed < NF) ? d[fed] : 32'h0;
      bus.out_ready = !(bus.out_valid && got == 0 && stalled < stall);
      if (poke_start && bus.out_valid) bus.start = 1'b1;
      if (abort_at >= 0 && bus.q_en && fed == abort_at + 1) begin
        bus.abort = 1'b1;
        aborted = 1;
      end
      #1;
      if (bus.q_en && fed > 0) begin
        checks++; if (bus.q_value !== d[fed-1]) $display("FAIL q_value: got %h want %h", bus.q_value, d[fed-1]); else passed++;
      end else if (!bus.q_en) begin
        checks++; if (bus.q_value !== 32'h0) $display("FAIL q_value_idle: got %h want 0", bus.q_value); else passed++;
      end
      if (aborted) begin
        checks++; if (bus.out_index !== IDX_W'(abort_at)) $display("FAIL abort_index: got %0d want %0d", bus.out_index, abort_at); else passed++;
      end else begin
        if (bus.out_valid) begin
          checks++; if (bus.in_ready !== 1'b0) $display("FAIL in_ready_emit: got %b want 0", bus.in_ready); else passed++;
          if (stalled > 0) begin
            checks++;
            if ({bus.out_level, bus.out_index} !== {s_lvl, s_idx})
              $display("FAIL stall_stable: got lvl %0d idx %0d want lvl %0d idx %0d", bus.out_level, bus.out_index, s_lvl, s_idx);
            else passed++;
          end else begin
            s_lvl = bus.out_level; s_idx = bus.out_index;
          end
          if (bus.out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
              $display("FAIL sb_empty: got output idx %0d want none", bus.out_index);
            end else begin
              e = exp_q.pop_front();
              if ({bus.out_level, bus.out_index, bus.out_last} !== e)
                $display("FAIL sb_out: got lvl %0d idx %0d last %b want lvl %0d idx %0d last %b",
                         bus.out_level, bus.out_index, bus.out_last, e.lvl, e.idx, e.last);
              else passed++;
            end
            got++;
            stalled = 0;
          end else begin
            stalled++;
          end
        end
        if (bus.in_valid && bus.in_ready) begin
          exp_q.push_back('{lvl: lv[fed], idx: IDX_W'(fed), last: (fed == NF - 1)});
          fed++;
        end
        if (got == NF) finished = 1;
      end
    end
    if (abort_at >= 0) begin
      checks++; if (!aborted) $display("FAIL abort_reached: got 0 want 1"); else passed++;
    end
    if (aborted) begin
      @(negedge clk);
      bus.abort = 1'b0; bus.in_valid = 1'b0; #1;
      checks++; if (bus.busy !== 1'b0) $display("FAIL abort_busy: got %b want 0", bus.busy); else passed++;
      checks++; if (bus.out_valid !== 1'b0) $display("FAIL abort_out_valid: got %b want 0", bus.out_valid); else passed++;
      checks++; if (bus.out_index !== '0) $display("FAIL abort_idx_clr: got %0d want 0", bus.out_index); else passed++;
      for (int i = 0; i < 4; i++) begin
        checks++; if (bus.done !== 1'b0) $display("FAIL abort_no_done: got %b want 0", bus.done); else passed++;
        @(negedge clk); #1;
      end
      exp_q.delete();
    end else if (!finished) begin
      checks++; $display("FAIL frame_timeout: got %0d outputs want %0d", got, NF);
    end else begin
      @(negedge clk);
      bus.start = 1'b0; bus.abort = 1'b0; bus.in_valid = 1'b0; #1;
      checks++; if (bus.done !== 1'b1) $display("FAIL done_pulse: got %b want 1", bus.done); else passed++;
      checks++; if (cyc !== 3 * NF + stall) $display("FAIL frame_latency: got %0d cycles want %0d", cyc, 3 * NF + stall); else passed++;
      checks++; if (exp_q.size() !== 0) $display("FAIL sb_leftover: got %0d want 0", exp_q.size()); else passed++;
      @(negedge clk); #1;
      checks++; if (bus.done !== 1'b0) $display("FAIL done_single: got %b want 0", bus.done); else passed++;
      checks++; if (bus.busy !== 1'b0) $display("FAIL idle_after_done: got %b want 0", bus.busy); else passed++;
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    bus.start = 1'b1; bus.in_valid = 1'b1; #1;
    checks++; if (bus.busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", bus.busy); else passed++;
    checks++; if (bus.done !== 1'b0) $display("FAIL rst_done: got %b want 0", bus.done); else passed++;
    checks++; if (bus.in_ready !== 1'b0) $display("FAIL rst_in_ready: got %b want 0", bus.in_ready); else passed++;
    checks++; if (bus.out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b want 0", bus.out_valid); else passed++;
    checks++; if ({bus.q_en, bus.q_value} !== 33'h0) $display("FAIL rst_q: got %b/%h want 0/0", bus.q_en, bus.q_value); else passed++;
    checks++; if (bus.q_nrst !== 1'b0) $display("FAIL rst_q_nrst: got %b want 0", bus.q_nrst); else passed++;
    checks++; if ({bus.out_level, bus.out_index, bus.out_last} !== '0) $display("FAIL rst_out_bus: got %h want 0", {bus.out_level, bus.out_index, bus.out_last}); else passed++;
`ifdef QSEQ_NAN_GUARD_EN
    checks++; if (bus.err_nan !== 1'b0) $display("FAIL rst_err_nan: got %b want 0", bus.err_nan); else passed++;
`endif
    bus.start = 1'b0; bus.in_valid = 1'b0;
    @(negedge clk); rst = 1'b0; #1;
    checks++; if (bus.q_nrst !== 1'b1) $display("FAIL q_nrst_run: got %b want 1", bus.q_nrst); else passed++;
    @(negedge clk); #1;
    checks++; if (bus.busy !== 1'b0) $display("FAIL idle_no_start: got %b want 0", bus.busy); else passed++;
  endtask

  task automatic test_basic_frame();
    logic [31:0] d [NF];
    logic [3:0] lv [NF];
    d = '{32'h3F800000, 32'h00000000, 32'hBF800000};
    lv = '{4'd0, 4'd5, 4'd9};
    run_frame(d, lv, 0, -1, 1'b0);
  endtask

  task automatic test_backpressure();
    logic [31:0] d [NF];
    logic [3:0] lv [NF];
    d = '{32'hBF800000, 32'h3F800000, 32'h00000000};
    lv = '{4'd9, 4'd0, 4'd5};
    run_frame(d, lv, 5, -1, 1'b0);
  endtask

  task automatic test_abort();
    logic [31:0] d [NF];
    logic [3:0] lv [NF];
    d = '{32'h3F800000, 32'h00000000, 32'hBF800000};
    lv = '{4'd0, 4'd5, 4'd9};
    run_frame(d, lv, 0, 1, 1'b0);
    run_frame(d, lv, 0, -1, 1'b0);
  endtask

  task automatic test_clamp_start_busy();
    logic [31:0] d [NF];
    logic [3:0] lv [NF];
    d = '{32'h3F800000, 32'h00000000, 32'hBF800000};
    lv = '{4'd9, 4'd9, 4'd9};
    force_en = 1'b1; force_val = 4'hC;
    run_frame(d, lv, 0, -1, 1'b1);
    force_en = 1'b0;
  endtask

  task automatic test_reset_mid_emit();
    int n = 0;
    logic [31:0] d [NF];
    logic [3:0] lv [NF];
    @(negedge clk);
    bus.start = 1'b1; bus.out_ready = 1'b0;
    @(negedge clk);
    bus.start = 1'b0; bus.in_valid = 1'b1; bus.in_data = 32'hBF800000;
    while (!bus.out_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    checks++; if (bus.out_valid !== 1'b1) $display("FAIL reach_emit: got %b want 1", bus.out_valid); else passed++;
    #2 rst = 1'b1;
    #1;
    checks++; if (bus.out_valid !== 1'b0) $display("FAIL arst_out_valid: got %b want 0", bus.out_valid); else passed++;
    checks++; if (bus.busy !== 1'b0) $display("FAIL arst_busy: got %b want 0", bus.busy); else passed++;
    checks++; if (bus.done !== 1'b0) $display("FAIL arst_done: got %b want 0", bus.done); else passed++;
    checks++; if (bus.q_nrst !== 1'b0) $display("FAIL arst_q_nrst: got %b want 0", bus.q_nrst); else passed++;
    checks++; if (bus.out_level !== 4'd0) $display("FAIL arst_level: got %0d want 0", bus.out_level); else passed++;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      checks++; if ({bus.busy, bus.done} !== 2'b00) $display("FAIL post_rst_idle: got %b want 00", {bus.busy, bus.done}); else passed++;
    end
    d = '{32'h00000000, 32'hBF800000, 32'h3F800000};
    lv = '{4'd5, 4'd9, 4'd0};
    run_frame(d, lv, 0, -1, 1'b0);
  endtask

`ifdef QSEQ_NAN_GUARD_EN
  task automatic test_nan_guard();
    logic [31:0] d [NF];
    logic [3:0] lv [NF];
    d = '{32'h7FC00000, 32'h3F800000, 32'h00000000};
    lv = '{4'd4, 4'd0, 4'd5};
    run_frame(d, lv, 0, -1, 1'b0);
    repeat (2) @(negedge clk);
    #1;
    checks++; if (bus.err_nan !== 1'b1) $display("FAIL err_nan_sticky: got %b want 1", bus.err_nan); else passed++;
    @(negedge clk); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0; #1;
    checks++; if (bus.err_nan !== 1'b0) $display("FAIL err_nan_clear: got %b want 0", bus.err_nan); else passed++;
    bus.abort = 1'b1;
    @(negedge clk); bus.abort = 1'b0;
  endtask
`endif

  initial begin
    rst = 1'b1;
    bus.start = 1'b0; bus.abort = 1'b0; bus.in_valid = 1'b0;
    bus.in_data = 32'h0; bus.out_ready = 1'b0;
    test_reset();
    test_basic_frame();
    test_backpressure();
    test_abort();
    test_clamp_start_busy();
    test_reset_mid_emit();
`ifdef QSEQ_NAN_GUARD_EN
    test_nan_guard();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got time %0t want finish before 100000", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
